ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: the sending side of the PS/2 link whose device-to-host bytes the mouse controller receives. It sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset):

- inhibits the bus;
- issues request-to-send;
- shifts out data and parity on device-generated clock edges;
- checks the device ACK bit.

It sits in the mouse clock domain next to the mouse controller. The top level converts its open-collector enables into the tristate drive on PS2Clk/PS2Data.

## Interface
Parameters:
- INHIBIT_CYCLES, 9750 — clk cycles the PS/2 clock is held low before RTS (100 µs at 97.5 MHz)
- RTS_CYCLES, 98 — cycles data and clock are both held low before clock release (~1 µs)
- TIMEOUT_CYCLES, 1462500 — max cycles allowed between device clock falling edges, and from clock release to the first edge (15 ms)

Ports:
- clk  in  1  module clock; one clock only
- rst  in  1  synchronous, active-high reset
- tx_start  in  1  one-cycle request to send tx_data; honoured only when busy=0
- tx_data  in  8  command byte; captured on accepted tx_start
- ps2_clk_in  in  1  raw PS/2 clock pad value (asynchronous)
- ps2_data_in  in  1  raw PS/2 data pad value (asynchronous)
- ps2_clk_oe  out  1  1 = drive PS2Clk low, 0 = release (high-Z)
- ps2_data_oe  out  1  1 = drive PS2Data low, 0 = release
- busy  out  1  high from accepted tx_start until done/err cycle inclusive
- done  out  1  one-cycle pulse: byte sent and ACK (data low) received
- err  out  1  one-cycle pulse: timeout or NACK; never in the same cycle as done

## Operation
- Pad inputs pass through a 2-flop synchronizer. A clock falling edge is sync'd value 1→0 between consecutive cycles.
- Shift frame is {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first. Parity is odd.
- A driven bit of 0 sets ps2_data_oe=1; a driven bit of 1 sets ps2_data_oe=0.
- FSM states:
  - IDLE: both oe=0, busy=0. On tx_start: latch the frame, clear the counters, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_CYCLES cycles, then RTS.
  - RTS: clk_oe=1, data_oe=1 (start bit 0), for RTS_CYCLES cycles, then clk_oe=0 and go to SHIFT.
  - SHIFT: data_oe holds the start bit (1). On each falling edge, bit_cnt k=0..8 places frame bit k (data 0–7, then parity). On falling edge k=9 the stop bit is placed (data_oe=0), then go to ACK.
  - ACK: on the next falling edge, sample synced data. 0 → WAIT_IDLE; 1 → err, then IDLE.
  - WAIT_IDLE: wait until synced clk=1 and data=1, then pulse done and go to IDLE.
- Timeout:
  - A counter runs in SHIFT, ACK and WAIT_IDLE and is cleared on every falling edge.
  - When it reaches TIMEOUT_CYCLES-1: pulse err, release both lines, go to IDLE.
- Edge handling:
  - Falling edges seen in IDLE, INHIBIT or RTS are ignored.
  - tx_start while busy is ignored; tx_data is not re-captured.
- Reset: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, counters 0, frame 0. Reset mid-frame releases both lines on the next clk edge.

## Timing
- tx_start at cycle t → busy=1 and clk_oe=1 at t+1. INHIBIT occupies cycles t+1 … t+INHIBIT_CYCLES.
- data_oe rises at t+INHIBIT_CYCLES+1. clk_oe falls at t+INHIBIT_CYCLES+RTS_CYCLES+1.
- Pad falling edge to data_oe update is 3 cycles: 2 synchronizer stages plus the registered output.
- done/err are registered and 1 cycle wide. busy falls the cycle after the done/err cycle.
- Counters:
  - Phase counter width is $clog2(max(INHIBIT_CYCLES,RTS_CYCLES)).
  - Timeout counter width is $clog2(TIMEOUT_CYCLES).
  - bit_cnt is 4 bits, range 0..9.
  - No counter wraps; each saturates or is cleared on a state change.

## Structure
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE;
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_RATE=8'hF3;
  - PS2_RESP_ACK=8'hFA.
- Sub-module ps2_line_sync: 2-flop synchronizer plus registered previous value and a fall output. Instantiated once for the clock line and once for the data line.
- All outputs are driven from flops; no combinational path from pad to oe.

## Test plan
Bench uses INHIBIT_CYCLES=20, RTS_CYCLES=4, TIMEOUT_CYCLES=200, with a device model that toggles the clock every 8 cycles.
- Reset: rst high 3 cycles → all outputs 0. tx_start asserted during rst → ignored, busy stays 0.
- Send 0xF4, device ACKs with 0:
  - clk_oe high for exactly 20 cycles, then data_oe high 4 cycles before clk release;
  - device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - done pulses once, err stays 0.
- Send 0x00: parity bit is 1. Device NACKs (data high on edge 11) → err pulses, done stays 0, both oe=0 on the next cycle.
- Device never clocks after RTS → err pulses 200 cycles after clk release, lines released, busy falls.
- Second tx_start(0xFF) during busy → ignored, first frame completes unchanged. rst asserted after edge 5 → both oe=0 the next cycle, state IDLE. A fresh 0xFF then completes with done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad, with a registered previous value for edge detection.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic sync_p0, sync_p1, prev_p2;

  // Reset to the idle-high bus level so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= pad;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 9750,
  parameter int RTS_CYCLES     = 98,
  parameter int TIMEOUT_CYCLES = 1462500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [PH_W-1:0] phase_cnt, phase_cnt_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [9:0]      frame, frame_n;
  logic            clk_oe_n, data_oe_n, busy_n, done_n, err_n;
  logic            clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .pad   (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  always_comb begin
    state_n     = state;
    phase_cnt_n = phase_cnt;
    to_cnt_n    = to_cnt;
    bit_cnt_n   = bit_cnt;
    frame_n     = frame;
    clk_oe_n    = ps2_clk_oe;
    data_oe_n   = ps2_data_oe;
    done_n      = 1'b0;
    err_n       = 1'b0;

    unique case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_start && !busy) begin
          frame_n     = {1'b1, odd_parity(tx_data), tx_data};
          phase_cnt_n = '0;
          to_cnt_n    = '0;
          bit_cnt_n   = '0;
          clk_oe_n    = 1'b1;
          state_n     = INHIBIT;
        end
      end
      INHIBIT: begin
        if (phase_cnt == INH_LAST) begin
          phase_cnt_n = '0;
          data_oe_n   = 1'b1;
          state_n     = RTS;
        end else begin
          phase_cnt_n = phase_cnt + 1'b1;
        end
      end
      RTS: begin
        if (phase_cnt == RTS_LAST) begin
          phase_cnt_n = '0;
          to_cnt_n    = '0;
          clk_oe_n    = 1'b0;
          state_n     = SHIFT;
        end else begin
          phase_cnt_n = phase_cnt + 1'b1;
        end
      end
      // bit_cnt stays at 9 once the stop bit is placed.
      SHIFT: begin
        if (clk_fall) begin
          data_oe_n = ~frame[bit_cnt];
          if (bit_cnt == 4'd9) state_n = ACK;
          else bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          if (!data_lvl) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A falling edge always restarts the watchdog; completion takes priority over expiry.
    if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      if (clk_fall) begin
        to_cnt_n = '0;
      end else if (to_cnt == TO_LAST) begin
        if (!done_n) begin
          err_n     = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end

    busy_n = (state_n != IDLE) || done_n || err_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      phase_cnt   <= phase_cnt_n;
      to_cnt      <= to_cnt_n;
      bit_cnt     <= bit_cnt_n;
      frame       <= frame_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector pad model and a simple PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tx_start;
  logic [7:0] tx_data;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;

  int checks = 0, failures = 0;
  int done_seen = 0, err_seen = 0, both_seen = 0;
  logic err_clk_oe = 1'b1, err_data_oe = 1'b1, err_busy = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .RTS_CYCLES     (4),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always @(negedge clk) begin
    if (done) done_seen++;
    if (err) begin
      err_seen++;
      err_clk_oe  = ps2_clk_oe;
      err_data_oe = ps2_data_oe;
      err_busy    = busy;
    end
    if (done && err) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (ps2_clk_oe && n < 100) begin
      tick();
      n++;
    end
    check(tag, ps2_clk_oe, 1'b0);
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  // Device: clock low 8 cycles, high 8 cycles; samples data on each rising edge.
  task automatic dev_frame(input int nbits, input bit ack_edge, input bit ack_low,
                           output logic [9:0] bits);
    bits = '0;
    repeat (4) tick();
    for (int e = 0; e < nbits; e++) begin
      dev_clk = 1'b0;
      repeat (8) tick();
      dev_clk = 1'b1;
      bits[e] = ps2_data_in;
      repeat (8) tick();
    end
    if (ack_edge) begin
      dev_data = !ack_low;
      repeat (4) tick();
      dev_clk = 1'b0;
      repeat (8) tick();
      dev_clk = 1'b1;
      repeat (2) tick();
      dev_data = 1'b1;
    end
  endtask

  initial begin
    int n, d0, e0;
    logic [9:0] bits;

    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = PS2_CMD_ENABLE;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst      = 1'b0;
    tx_start = 1'b0;
    tick();
    check("start_in_rst_ignored", busy, 1'b0);

    // 0xF4 with ACK
    d0 = done_seen; e0 = err_seen;
    send_start(PS2_CMD_ENABLE);
    check("f4_busy", busy, 1'b1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin n++; tick(); end
    check("inhibit_len", n, 20);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 100) begin n++; tick(); end
    check("rts_len", n, 4);
    check("start_bit_held", ps2_data_oe, 1'b1);
    check("clk_released", ps2_clk_oe, 1'b0);
    dev_frame(10, 1'b1, 1'b1, bits);
    check("frame_f4", bits, 10'h2F4);
    wait_not_busy("f4_busy_fall");
    check("f4_done", done_seen - d0, 1);
    check("f4_no_err", err_seen - e0, 0);

    // 0x00 with NACK
    d0 = done_seen; e0 = err_seen;
    send_start(8'h00);
    wait_release("n00_release");
    dev_frame(10, 1'b1, 1'b0, bits);
    check("frame_00", bits, 10'h300);
    wait_not_busy("n00_busy_fall");
    check("nack_err", err_seen - e0, 1);
    check("nack_no_done", done_seen - d0, 0);
    check("nack_clk_oe", err_clk_oe, 1'b0);
    check("nack_data_oe", err_data_oe, 1'b0);
    check("nack_busy_in_err", err_busy, 1'b1);

    // Device never clocks
    send_start(PS2_CMD_ENABLE);
    wait_release("to_release");
    n = 0;
    while (!err && n < 400) begin tick(); n++; end
    check("timeout_cycles", n, 200);
    check("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("timeout_data_oe", ps2_data_oe, 1'b0);
    tick();
    check("timeout_busy_fall", busy, 1'b0);

    // Second tx_start while busy is ignored
    d0 = done_seen; e0 = err_seen;
    send_start(PS2_CMD_SET_RATE);
    repeat (5) tick();
    tx_data  = PS2_CMD_RESET;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data  = 8'h00;
    wait_release("f3_release");
    dev_frame(10, 1'b1, 1'b1, bits);
    check("frame_f3_kept", bits, 10'h3F3);
    wait_not_busy("f3_busy_fall");
    check("f3_done", done_seen - d0, 1);
    check("f3_no_err", err_seen - e0, 0);

    // Reset after edge 5
    send_start(PS2_CMD_RESET);
    wait_release("ff_release");
    dev_frame(5, 1'b0, 1'b0, bits);
    check("ff_first5", bits, 10'h01F);
    check("ff_busy_mid", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_clk_oe", ps2_clk_oe, 1'b0);
    check("midrst_data_oe", ps2_data_oe, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Fresh 0xFF after reset
    d0 = done_seen; e0 = err_seen;
    send_start(PS2_CMD_RESET);
    check("ff2_busy", busy, 1'b1);
    wait_release("ff2_release");
    dev_frame(10, 1'b1, 1'b1, bits);
    check("frame_ff", bits, 10'h3FF);
    wait_not_busy("ff2_busy_fall");
    check("ff2_done", done_seen - d0, 1);
    check("ff2_no_err", err_seen - e0, 0);
    check("done_err_exclusive", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
